// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: RISC-V opcode, quadrant and
// funct3 encodings used by predecode, the FSM state type and the queue entry type.
package fetch_unit_pkg;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // Compressed quadrants (inst[1:0]); 2'b11 marks a full 32-bit instruction
    localparam logic [1:0] QUAD_1  = 2'b01;
    localparam logic [1:0] QUAD_2  = 2'b10;
    localparam logic [1:0] QUAD_32 = 2'b11;

    localparam logic [2:0] F3_CJAL  = 3'b001;
    localparam logic [2:0] F3_CJ    = 3'b101;
    localparam logic [2:0] F3_CBEQZ = 3'b110;
    localparam logic [2:0] F3_CBNEZ = 3'b111;
    localparam logic [2:0] F3_CJR   = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WAIT  = 2'b01,
        ST_STALL = 2'b10
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pred_pc;
        logic        is_c;
    } fetch_entry_t;

    localparam fetch_entry_t ENTRY_ZERO = '{inst: 32'h0000_0000, pc: 32'h0000_0000,
                                           pred_pc: 32'h0000_0000, is_c: 1'b0};

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: memory request/response, redirect and instruction output.
// master = fetch unit side, slave = memory/consumer environment side.
interface fetch_unit_if;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_valid;
    logic [31:0] mem_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [31:0] out_pred_pc;
    logic        out_is_c;
    logic        out_stall_jalr;

    modport master (
        input  redirect, redirect_pc, mem_valid, mem_data, out_ready,
        output mem_req, mem_addr, out_valid, out_inst, out_pc, out_pred_pc,
               out_is_c, out_stall_jalr
    );

    modport slave (
        output redirect, redirect_pc, mem_valid, mem_data, out_ready,
        input  mem_req, mem_addr, out_valid, out_inst, out_pc, out_pred_pc,
               out_is_c, out_stall_jalr
    );
endinterface

// File: rtl/fetch_unit_predecode.sv
// Combinational predecode: instruction size, immediate extraction and next-pc
// prediction for one fetched word at a given pc.
module fetch_predecode
    import fetch_unit_pkg::*;
#(
    parameter int unsigned PREDICT_MODE = 1
) (
    input  logic [31:0]  raw_i,
    input  logic [31:0]  pc_i,
    output fetch_entry_t entry_o,
    output logic         is_jalr_o
);
    localparam logic BTFN_C = (PREDICT_MODE == 32'd1);

    logic        is_c_s;
    logic        take_s;
    logic [31:0] imm_s;
    logic [31:0] step_s;

    // Decode size and control-flow class; conditional branches are taken only
    // when backward (negative offset) and the backward-taken policy is enabled.
    always_comb begin
        is_c_s    = (raw_i[1:0] != QUAD_32);
        step_s    = is_c_s ? 32'd2 : 32'd4;
        imm_s     = 32'h0000_0000;
        take_s    = 1'b0;
        is_jalr_o = 1'b0;
        if (!is_c_s) begin
            case (raw_i[6:0])
                OPC_JAL: begin
                    imm_s  = {{11{raw_i[31]}}, raw_i[31], raw_i[19:12], raw_i[20],
                              raw_i[30:21], 1'b0};
                    take_s = 1'b1;
                end
                OPC_BRANCH: begin
                    imm_s  = {{19{raw_i[31]}}, raw_i[31], raw_i[7], raw_i[30:25],
                              raw_i[11:8], 1'b0};
                    take_s = BTFN_C && raw_i[31];
                end
                OPC_JALR: is_jalr_o = 1'b1;
                default:  take_s = 1'b0;
            endcase
        end else begin
            case ({raw_i[1:0], raw_i[15:13]})
                {QUAD_1, F3_CJ}, {QUAD_1, F3_CJAL}: begin
                    imm_s  = {{20{raw_i[12]}}, raw_i[12], raw_i[8], raw_i[10:9], raw_i[6],
                              raw_i[7], raw_i[2], raw_i[11], raw_i[5:3], 1'b0};
                    take_s = 1'b1;
                end
                {QUAD_1, F3_CBEQZ}, {QUAD_1, F3_CBNEZ}: begin
                    imm_s  = {{23{raw_i[12]}}, raw_i[12], raw_i[6:5], raw_i[2],
                              raw_i[11:10], raw_i[4:3], 1'b0};
                    take_s = BTFN_C && raw_i[12];
                end
                {QUAD_2, F3_CJR}: begin
                    // C.JR / C.JALR: rs2 zero, rs1 non-zero (excludes C.EBREAK)
                    if ((raw_i[6:2] == 5'd0) && (raw_i[11:7] != 5'd0)) begin
                        is_jalr_o = 1'b1;
                    end else begin
                        is_jalr_o = 1'b0;
                    end
                end
                default: take_s = 1'b0;
            endcase
        end
        entry_o.inst    = is_c_s ? {16'h0000, raw_i[15:0]} : raw_i;
        entry_o.pc      = pc_i;
        entry_o.pred_pc = take_s ? (pc_i + imm_s) : (pc_i + step_s);
        entry_o.is_c    = is_c_s;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: single-outstanding memory requester, predecode with
// static prediction, and a fetched-instruction queue with registered head outputs.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned QUEUE_DEPTH  = 8,
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned PREDICT_MODE = 1
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);
    localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(QUEUE_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);

    fetch_state_e state_q;
    logic [31:0]  fetch_pc_q;
    logic [31:0]  mem_addr_q;
    logic         mem_req_q;
    logic         stale_q;
    logic         stall_q;

    fetch_entry_t queue_q [QUEUE_DEPTH];
    fetch_entry_t head_q, head_d;
    logic         out_valid_q;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    fetch_entry_t pd_entry_s;
    logic         pd_is_jalr_s;
    logic         enq_s;
    logic         deq_s;

    fetch_predecode #(
        .PREDICT_MODE(PREDICT_MODE)
    ) u_predecode (
        .raw_i    (bus.mem_data),
        .pc_i     (fetch_pc_q),
        .entry_o  (pd_entry_s),
        .is_jalr_o(pd_is_jalr_s)
    );

    // Queue next state; a redirect flushes and overrides any same-cycle dequeue.
    always_comb begin
        enq_s    = (state_q == ST_WAIT) && bus.mem_valid && !stale_q && !bus.redirect;
        deq_s    = out_valid_q && bus.out_ready && !bus.redirect;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (bus.redirect) begin
            rd_ptr_d = PTR_ZERO;
            wr_ptr_d = PTR_ZERO;
            count_d  = CNT_ZERO;
        end else begin
            wr_ptr_d = enq_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
            rd_ptr_d = deq_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
            case ({enq_s, deq_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
        // The entry being written this cycle becomes head when it lands at rd_ptr_d
        if (enq_s && (wr_ptr_q == rd_ptr_d)) begin
            head_d = pd_entry_s;
        end else begin
            head_d = queue_q[rd_ptr_d];
        end
    end

    // Queue storage write.
    always_ff @(posedge clk) begin
        if (enq_s) begin
            queue_q[wr_ptr_q] <= pd_entry_s;
        end
    end

    // Queue pointers and registered head; head holds its last value while empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q    <= PTR_ZERO;
            wr_ptr_q    <= PTR_ZERO;
            count_q     <= CNT_ZERO;
            out_valid_q <= 1'b0;
            head_q      <= ENTRY_ZERO;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            out_valid_q <= (count_d != CNT_ZERO);
            if (count_d != CNT_ZERO) begin
                head_q <= head_d;
            end
        end
    end

    // Fetch FSM with registered request outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            mem_req_q  <= 1'b0;
            mem_addr_q <= RESET_PC;
            stale_q    <= 1'b0;
            stall_q    <= 1'b0;
        end else begin
            mem_req_q <= 1'b0;
            if (bus.redirect) begin
                state_q    <= ST_IDLE;
                fetch_pc_q <= {bus.redirect_pc[31:1], 1'b0};
                stall_q    <= 1'b0;
                // A request still in flight will answer later and must be dropped
                if ((state_q == ST_WAIT) && !bus.mem_valid) begin
                    stale_q <= 1'b1;
                end else if (bus.mem_valid) begin
                    stale_q <= 1'b0;
                end else begin
                    stale_q <= stale_q;
                end
            end else begin
                if (stale_q && bus.mem_valid) begin
                    stale_q <= 1'b0;
                end
                case (state_q)
                    ST_IDLE: begin
                        if (!stale_q && (count_q < DEPTH_C)) begin
                            mem_req_q  <= 1'b1;
                            mem_addr_q <= fetch_pc_q;
                            state_q    <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (enq_s) begin
                            fetch_pc_q <= pd_entry_s.pred_pc;
                            if (pd_is_jalr_s) begin
                                state_q <= ST_STALL;
                                stall_q <= 1'b1;
                            end else begin
                                state_q <= ST_IDLE;
                            end
                        end
                    end
                    ST_STALL: state_q <= ST_STALL;
                    default:  state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.mem_req        = mem_req_q;
    assign bus.mem_addr       = mem_addr_q;
    assign bus.out_valid      = out_valid_q;
    assign bus.out_inst       = head_q.inst;
    assign bus.out_pc         = head_q.pc;
    assign bus.out_pred_pc    = head_q.pred_pc;
    assign bus.out_is_c       = head_q.is_c;
    assign bus.out_stall_jalr = stall_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: u_dut uses QUEUE_DEPTH=4/backward-taken, u_dut0
// uses QUEUE_DEPTH=8/always-not-taken; both see identical inputs.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        mem_valid;
    logic [31:0] mem_data;
    logic        out_ready;
    int          checks = 0;
    int          failures = 0;

    fetch_unit_if if1 ();
    fetch_unit_if if0 ();

    assign if1.redirect    = redirect;
    assign if1.redirect_pc = redirect_pc;
    assign if1.mem_valid   = mem_valid;
    assign if1.mem_data    = mem_data;
    assign if1.out_ready   = out_ready;
    assign if0.redirect    = redirect;
    assign if0.redirect_pc = redirect_pc;
    assign if0.mem_valid   = mem_valid;
    assign if0.mem_data    = mem_data;
    assign if0.out_ready   = out_ready;

    fetch_unit #(.QUEUE_DEPTH(4), .RESET_PC(32'h0000_0000), .PREDICT_MODE(1)) u_dut (
        .clk(clk), .rst(rst), .bus(if1.master));
    fetch_unit #(.QUEUE_DEPTH(8), .RESET_PC(32'h0000_0000), .PREDICT_MODE(0)) u_dut0 (
        .clk(clk), .rst(rst), .bus(if0.master));

    always #5 clk = ~clk;

    task automatic do_reset();
        rst = 1'b1; redirect = 1'b0; mem_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_req(output bit ok, output logic [31:0] addr);
        ok = 1'b0; addr = 32'h0000_0000;
        for (int i = 0; i < 20; i++) begin
            if (!ok) begin
                if (if1.mem_req === 1'b1) begin
                    ok = 1'b1; addr = if1.mem_addr;
                end else begin
                    @(negedge clk);
                end
            end
        end
    endtask

    task automatic give_resp(input logic [31:0] data);
        mem_valid = 1'b1; mem_data = data;
        @(negedge clk);
        mem_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0500;
        mem_valid = 1'b1; mem_data = 32'h0000_0013; out_ready = 1'b1;
        @(negedge clk); @(negedge clk);
        checks++;
        if ({if1.mem_req, if1.mem_addr} !== 33'h0) begin
            failures++; $display("FAIL rst_req got req=%b addr=%h exp 0/0", if1.mem_req, if1.mem_addr);
        end
        checks++;
        if ({if1.out_valid, if1.out_is_c, if1.out_stall_jalr, if1.out_inst, if1.out_pc, if1.out_pred_pc} !== 99'h0) begin
            failures++; $display("FAIL rst_outs got v=%b inst=%h pc=%h pred=%h exp all zero",
                                 if1.out_valid, if1.out_inst, if1.out_pc, if1.out_pred_pc);
        end
        rst = 1'b0; redirect = 1'b0; mem_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (if1.mem_req !== 1'b1 || if1.mem_addr !== 32'h0000_0000) begin
            failures++; $display("FAIL first_req got req=%b addr=%h exp 1/00000000", if1.mem_req, if1.mem_addr);
        end
    endtask

    task automatic test_sequential();
        bit ok; logic [31:0] addr; logic [31:0] pc;
        out_ready = 1'b1; do_reset();
        for (int k = 0; k < 3; k++) begin
            pc = 32'(4 * k);
            wait_req(ok, addr);
            checks++;
            if (!ok || addr !== pc) begin
                failures++; $display("FAIL seq_addr%0d got ok=%b addr=%h exp %h", k, ok, addr, pc);
            end
            give_resp(32'h0000_0013);
            checks++;
            if (if1.out_valid !== 1'b1 || if1.out_pc !== pc || if1.out_pred_pc !== pc + 32'd4 ||
                if1.out_is_c !== 1'b0 || if1.out_inst !== 32'h0000_0013) begin
                failures++; $display("FAIL seq_out%0d got v=%b pc=%h pred=%h c=%b inst=%h exp pc=%h pred=%h",
                                     k, if1.out_valid, if1.out_pc, if1.out_pred_pc, if1.out_is_c, if1.out_inst, pc, pc + 32'd4);
            end
        end
    endtask

    task automatic test_branch();
        bit ok; logic [31:0] addr;
        out_ready = 1'b1; do_reset();
        wait_req(ok, addr);
        give_resp(32'h1000_006F);
        checks++;
        if (if1.out_pred_pc !== 32'h0000_0100 || if0.out_pred_pc !== 32'h0000_0100) begin
            failures++; $display("FAIL jal_pred got %h/%h exp 00000100", if1.out_pred_pc, if0.out_pred_pc);
        end
        wait_req(ok, addr);
        checks++;
        if (!ok || addr !== 32'h0000_0100) begin
            failures++; $display("FAIL jal_addr got ok=%b addr=%h exp 00000100", ok, addr);
        end
        give_resp(32'hFE00_0EE3);
        checks++;
        if (if1.out_pc !== 32'h0000_0100 || if1.out_pred_pc !== 32'h0000_00FC) begin
            failures++; $display("FAIL beq_btfn got pc=%h pred=%h exp 00000100/000000fc", if1.out_pc, if1.out_pred_pc);
        end
        checks++;
        if (if0.out_pred_pc !== 32'h0000_0104) begin
            failures++; $display("FAIL beq_nt got pred=%h exp 00000104", if0.out_pred_pc);
        end
        wait_req(ok, addr);
        checks++;
        if (!ok || addr !== 32'h0000_00FC || if0.mem_req !== 1'b1 || if0.mem_addr !== 32'h0000_0104) begin
            failures++; $display("FAIL beq_next got ok=%b addr=%h addr0=%h exp 000000fc/00000104", ok, addr, if0.mem_addr);
        end
    endtask

    task automatic test_stall_jalr();
        bit ok; logic [31:0] addr; int nreq;
        out_ready = 1'b1; do_reset();
        wait_req(ok, addr);
        give_resp(32'h2000_006F);
        wait_req(ok, addr);
        checks++;
        if (!ok || addr !== 32'h0000_0200) begin
            failures++; $display("FAIL cjr_addr got ok=%b addr=%h exp 00000200", ok, addr);
        end
        give_resp(32'hABCD_8082);
        checks++;
        if (if1.out_is_c !== 1'b1 || if1.out_inst !== 32'h0000_8082 || if1.out_pred_pc !== 32'h0000_0202 ||
            if1.out_stall_jalr !== 1'b1) begin
            failures++; $display("FAIL cjr_out got c=%b inst=%h pred=%h stall=%b exp 1/00008082/00000202/1",
                                 if1.out_is_c, if1.out_inst, if1.out_pred_pc, if1.out_stall_jalr);
        end
        nreq = 0;
        for (int i = 0; i < 6; i++) begin
            if (if1.mem_req === 1'b1) nreq++;
            @(negedge clk);
        end
        checks++;
        if (nreq !== 0) begin
            failures++; $display("FAIL stall_noreq got %0d requests exp 0", nreq);
        end
        redirect = 1'b1; redirect_pc = 32'h0000_0300;
        @(negedge clk);
        redirect = 1'b0;
        checks++;
        if (if1.out_stall_jalr !== 1'b0 || if1.out_valid !== 1'b0) begin
            failures++; $display("FAIL stall_clear got stall=%b v=%b exp 0/0", if1.out_stall_jalr, if1.out_valid);
        end
        wait_req(ok, addr);
        checks++;
        if (!ok || addr !== 32'h0000_0300) begin
            failures++; $display("FAIL redir_addr got ok=%b addr=%h exp 00000300", ok, addr);
        end
    endtask

    task automatic test_full();
        int nreq; logic [31:0] last_addr;
        out_ready = 1'b0; do_reset();
        nreq = 0;
        for (int i = 0; i < 30; i++) begin
            if (if1.mem_req === 1'b1) begin
                nreq++; mem_valid = 1'b1; mem_data = 32'h0000_0013;
            end else begin
                mem_valid = 1'b0;
            end
            @(negedge clk);
        end
        mem_valid = 1'b0;
        checks++;
        if (nreq !== 4) begin
            failures++; $display("FAIL full_count got %0d requests exp 4", nreq);
        end
        checks++;
        if (if1.mem_req !== 1'b0 || if1.out_valid !== 1'b1 || if1.out_pc !== 32'h0000_0000) begin
            failures++; $display("FAIL full_head got req=%b v=%b pc=%h exp 0/1/00000000", if1.mem_req, if1.out_valid, if1.out_pc);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        nreq = 0; last_addr = 32'hFFFF_FFFF;
        for (int i = 0; i < 20; i++) begin
            if (if1.mem_req === 1'b1) begin
                nreq++; last_addr = if1.mem_addr; mem_valid = 1'b1; mem_data = 32'h0000_0013;
            end else begin
                mem_valid = 1'b0;
            end
            @(negedge clk);
        end
        mem_valid = 1'b0;
        checks++;
        if (nreq !== 1 || last_addr !== 32'h0000_0010) begin
            failures++; $display("FAIL refill got %0d req addr=%h exp 1 req at 00000010", nreq, last_addr);
        end
        checks++;
        if (if1.out_valid !== 1'b1 || if1.out_pc !== 32'h0000_0004) begin
            failures++; $display("FAIL refill_head got v=%b pc=%h exp 1/00000004", if1.out_valid, if1.out_pc);
        end
    endtask

    task automatic test_redirect_wait();
        bit ok; logic [31:0] addr; int nreq;
        out_ready = 1'b1; do_reset();
        wait_req(ok, addr);
        redirect = 1'b1; redirect_pc = 32'h0000_0040;
        @(negedge clk);
        redirect = 1'b0;
        nreq = 0;
        for (int i = 0; i < 3; i++) begin
            if (if1.mem_req === 1'b1) nreq++;
            @(negedge clk);
        end
        checks++;
        if (nreq !== 0) begin
            failures++; $display("FAIL stale_noreq got %0d requests exp 0", nreq);
        end
        give_resp(32'h0000_0013);
        checks++;
        if (if1.out_valid !== 1'b0) begin
            failures++; $display("FAIL stale_drop got v=%b exp 0", if1.out_valid);
        end
        wait_req(ok, addr);
        checks++;
        if (!ok || addr !== 32'h0000_0040) begin
            failures++; $display("FAIL stale_addr got ok=%b addr=%h exp 00000040", ok, addr);
        end
        redirect = 1'b1; redirect_pc = 32'h0000_0080; mem_valid = 1'b1; mem_data = 32'h0000_0013;
        @(negedge clk);
        redirect = 1'b0; mem_valid = 1'b0;
        checks++;
        if (if1.out_valid !== 1'b0) begin
            failures++; $display("FAIL redir_valid_drop got v=%b exp 0", if1.out_valid);
        end
        wait_req(ok, addr);
        checks++;
        if (!ok || addr !== 32'h0000_0080) begin
            failures++; $display("FAIL redir2_addr got ok=%b addr=%h exp 00000080", ok, addr);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_stall_jalr();
        test_full();
        test_redirect_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter QUEUE_DEPTH, default 8, fetched-instruction queue entries; power of two, at least 2.
REQ-002 Parameter RESET_PC, default 32'h0, fetch address after reset.
REQ-003 Parameter PREDICT_MODE, default 1, conditional-branch policy: 0 = always not-taken, 1 = backward-taken/forward-not-taken.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 redirect  in  1  flush and restart fetch at redirect_pc.
REQ-007 redirect_pc  in  32  restart address.
REQ-008 mem_req  out  1  fetch request, one-cycle pulse.
REQ-009 mem_addr  out  32  request address, halfword aligned.
REQ-010 mem_valid  in  1  response strobe for the single outstanding request.
REQ-011 mem_data  in  32  response instruction bits.
REQ-012 out_valid  out  1  queue head valid.
REQ-013 out_ready  in  1  consumer accepts head.
REQ-014 out_inst  out  32  head instruction; 16-bit forms zero-extended.
REQ-015 out_pc  out  32  head instruction address.
REQ-016 out_pred_pc  out  32  predicted next address.
REQ-017 out_is_c  out  1  head is a compressed (16-bit) instruction.
REQ-018 out_stall_jalr  out  1  fetch stalled on indirect jump.

Function
REQ-019 At most one request outstanding; mem_req asserts only when idle, not stalled, not in redirect, and count + 1 <= QUEUE_DEPTH (slot reserved at issue).
REQ-020 States: IDLE (may issue), WAIT (request outstanding), STALL (indirect jump seen); IDLE->WAIT on mem_req, WAIT->IDLE on accepted mem_valid, WAIT->STALL on accepted indirect jump, STALL->IDLE only on redirect.
REQ-021 Size from mem_data[1:0]: 2'b11 = 32-bit (step 4), else 16-bit (step 2, out_inst upper 16 bits zero).
REQ-022 Prediction, 32-bit arithmetic modulo 2^32: JAL and C.J/C.JAL (quadrant 01, funct3 101/001) -> pc + sign-extended imm; B-type and C.BEQZ/C.BNEZ -> pc + imm when PREDICT_MODE=1 and imm negative, else pc + step; JALR, C.JR, C.JALR -> out_pred_pc = pc + step and enter STALL; others -> pc + step.
REQ-023 Accepted response enqueues {inst, pc, pred_pc, is_c} in the cycle of mem_valid; fetch_pc becomes pred_pc; out_valid for that entry is visible next cycle.
REQ-024 Dequeue when out_valid && out_ready; simultaneous enqueue and dequeue leaves count unchanged; pointers wrap modulo QUEUE_DEPTH.
REQ-025 Empty: out_valid=0, out_* hold last value; full: mem_req held low, no overflow possible.
REQ-026 redirect: queue emptied, fetch_pc=redirect_pc, state IDLE, next mem_req no earlier than the following cycle; dequeue in the redirect cycle is ignored.
REQ-027 Redirect while WAIT: the next mem_valid is discarded (stale flag); mem_valid in the redirect cycle itself is discarded.
REQ-028 mem_valid while not WAIT and no stale flag is ignored.

Reset
REQ-029 On rst: fetch_pc=RESET_PC, state IDLE, queue empty, stale flag clear, mem_req=0, mem_addr=RESET_PC, out_valid=0, out_inst/out_pc/out_pred_pc=0, out_is_c=0, out_stall_jalr=0.
REQ-030 rst overrides redirect and mem_valid in the same cycle; outstanding response after rst is discarded.
REQ-031 First mem_req asserts the first cycle after rst deasserts.

Structure
REQ-032 Shared package holds opcode/quadrant/funct3 constants and the fetch entry struct type.
REQ-033 One sub-module fetch_predecode: combinational size, immediate extraction, prediction from {inst, pc, PREDICT_MODE}.

Verification
REQ-034 Reset, RESET_PC=0, mem_data=32'h00000013 each response, out_ready=1 -> pcs 0,4,8, out_is_c=0.
REQ-035 pc 0x100 returns 0xFE000EE3 (BEQ -4) with PREDICT_MODE=1 -> out_pred_pc=0x0FC, next mem_addr=0x0FC; PREDICT_MODE=0 -> 0x104.
REQ-036 pc 0x200 returns 16'h8082 (C.JR ra) -> out_is_c=1, out_stall_jalr=1, no mem_req until redirect to 0x300, then mem_addr=0x300.
REQ-037 out_ready=0, QUEUE_DEPTH=4 -> exactly 4 requests, mem_req low while full; one dequeue -> one new request.
REQ-038 redirect to 0x40 while WAIT -> following mem_valid discarded, queue empty, next request mem_addr=0x40.
